// File: rtl/dircc_system_nios_single_timer_sequencer.sv
// Shares one single-shot Avalon-MM interval timer between NUM_REQ requesters:
// round-robin grant, timer programming, irq wait, status clear, done pulse.
module dircc_system_nios_single_timer_sequencer #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [32*NUM_REQ-1:0]  req_period,
  input  logic [NUM_REQ-1:0]     req_cancel,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     done,
  output logic                   done_timeout,
  output logic                   busy,
  output logic [PTR_W-1:0]       owner,
  output logic [2:0]             tmr_address,
  output logic                   tmr_chipselect,
  output logic                   tmr_write_n,
  output logic [15:0]            tmr_writedata,
  input  logic                   tmr_irq,
  output logic [3:0]             state_dbg
);

  // Handshake: a request transfers in the cycle where req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot and only asserted in IDLE.
  typedef enum logic [3:0] {
    S_IDLE, S_WR_STOP, S_WR_PL, S_WR_PH, S_WR_CLR, S_WR_START,
    S_WAIT, S_CSTOP, S_ACK, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [PTR_W-1:0]   last_grant;
  logic [PTR_W-1:0]   owner_q;
  logic [31:0]        period_q;
  logic               flag_q;

  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  int                 idx;
  int                 win_base;
  logic [31:0]        sel_period;
  logic               accept;
  logic               cancel_own;
  logic [NUM_REQ-1:0] one_hot_base;
  logic [NUM_REQ-1:0] owner_onehot;

  assign one_hot_base = {{(NUM_REQ-1){1'b0}}, 1'b1};
  assign owner_onehot = one_hot_base << owner_q;
  assign cancel_own   = |(req_cancel & owner_onehot);

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (!win_found && req_valid[idx]) begin
        win_found = 1'b1;
        win_idx   = PTR_W'(idx);
      end
    end
    win_base   = int'(win_idx) * 32;
    sel_period = req_period[win_base +: 32];
  end

  assign accept    = (state == S_IDLE) && win_found;
  assign req_ready = accept ? (one_hot_base << win_idx) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= PTR_W'(NUM_REQ - 1);
      owner_q    <= '0;
      period_q   <= '0;
      flag_q     <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        last_grant <= win_idx;
        owner_q    <= win_idx;
        // A zero period never yields a zero-crossing, so the timer would hang.
        period_q   <= (sel_period == 32'd0) ? 32'd1 : sel_period;
      end
      if (state == S_WAIT) begin
        if (tmr_irq)         flag_q <= 1'b1;
        else if (cancel_own) flag_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (accept) state_nx = S_WR_STOP;
      S_WR_STOP:  state_nx = S_WR_PL;
      S_WR_PL:    state_nx = S_WR_PH;
      S_WR_PH:    state_nx = S_WR_CLR;
      S_WR_CLR:   state_nx = S_WR_START;
      S_WR_START: state_nx = S_WAIT;
      S_WAIT: begin
        if (tmr_irq)         state_nx = S_ACK;
        else if (cancel_own) state_nx = S_CSTOP;
      end
      S_CSTOP:    state_nx = S_ACK;
      S_ACK:      state_nx = S_DONE;
      S_DONE:     state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  // Bus outputs decode from state and latched period only.
  always_comb begin
    tmr_chipselect = 1'b0;
    tmr_write_n    = 1'b1;
    tmr_address    = 3'd0;
    tmr_writedata  = 16'h0000;
    case (state)
      S_WR_STOP, S_CSTOP: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0008;
      end
      S_WR_PL: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd2;
        tmr_writedata  = period_q[15:0];
      end
      S_WR_PH: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd3;
        tmr_writedata  = period_q[31:16];
      end
      S_WR_CLR, S_ACK: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
      end
      S_WR_START: begin
        tmr_chipselect = 1'b1;
        tmr_write_n    = 1'b0;
        tmr_address    = 3'd1;
        tmr_writedata  = 16'h0005;
      end
      default: ;
    endcase
  end

  assign done         = (state == S_DONE) ? owner_onehot : '0;
  assign done_timeout = (state == S_DONE) && flag_q;
  assign busy         = (state != S_IDLE);
  assign owner        = owner_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_dircc_system_nios_single_timer_sequencer.sv
// Bench for the timer sequencer: transaction-queue reference model checked every
// cycle, plus directed scenarios with literal bus-write and done expectations.
module tb_dircc_system_nios_single_timer_sequencer;
  localparam int N  = 2;
  localparam int PW = 3;

  logic            clk;
  logic            reset_n;
  logic [N-1:0]    req_valid;
  logic [32*N-1:0] req_period;
  logic [N-1:0]    req_cancel;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    done;
  logic            done_timeout;
  logic            busy;
  logic [PW-1:0]   owner;
  logic [2:0]      tmr_address;
  logic            tmr_chipselect;
  logic            tmr_write_n;
  logic [15:0]     tmr_writedata;
  logic            tmr_irq;
  logic [3:0]      state_dbg;
  logic            irq_man, irq_auto, auto_irq;

  assign tmr_irq = irq_man | irq_auto;

  dircc_system_nios_single_timer_sequencer #(.NUM_REQ(N), .PTR_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_period(req_period),
    .req_cancel(req_cancel), .req_ready(req_ready), .done(done),
    .done_timeout(done_timeout), .busy(busy), .owner(owner),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_irq(tmr_irq), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each accepted job becomes a list of expected bus cycles; an empty list
  // while a job is open means the sequencer is waiting for irq or cancel.
  typedef struct packed {
    logic        cs;
    logic [2:0]  addr;
    logic [15:0] data;
    logic        dn;
    logic        dto;
  } ent_t;

  ent_t mq[$];
  ent_t cur;
  bit   job, waiting;
  int   m_owner, m_last;

  function automatic ent_t mk(input logic cs, input logic [2:0] a, input logic [15:0] d,
                              input logic dn, input logic dto);
    ent_t e;
    e.cs = cs; e.addr = a; e.data = d; e.dn = dn; e.dto = dto;
    return e;
  endfunction

  function automatic int winner(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      cur = '0; job = 0; waiting = 0; m_owner = 0; m_last = N - 1;
    end else begin
      if (!job) begin
        int w;
        logic [31:0] p;
        w = winner(req_valid, m_last);
        if (w >= 0) begin
          job = 1; m_owner = w; m_last = w;
          p = req_period[w*32 +: 32];
          if (p == 0) p = 1;
          mq.push_back(mk(1, 3'd1, 16'h0008, 0, 0));
          mq.push_back(mk(1, 3'd2, p[15:0], 0, 0));
          mq.push_back(mk(1, 3'd3, p[31:16], 0, 0));
          mq.push_back(mk(1, 3'd0, 16'h0000, 0, 0));
          mq.push_back(mk(1, 3'd1, 16'h0005, 0, 0));
        end
      end else if (cur.dn) begin
        job = 0;
      end else if (waiting) begin
        if (tmr_irq) begin
          mq.push_back(mk(1, 3'd0, 16'h0000, 0, 0));
          mq.push_back(mk(0, 3'd0, 16'h0000, 1, 1));
        end else if (req_cancel[m_owner]) begin
          mq.push_back(mk(1, 3'd1, 16'h0008, 0, 0));
          mq.push_back(mk(1, 3'd0, 16'h0000, 0, 0));
          mq.push_back(mk(0, 3'd0, 16'h0000, 1, 0));
        end
      end
      if (mq.size() > 0) begin
        cur = mq.pop_front();
        waiting = 0;
      end else begin
        cur = '0;
        waiting = job;
      end
    end
  end

  // Compare process: every cycle out of reset.
  always @(negedge clk) begin
    if (reset_n) begin
      logic [29:0] got, exp;
      logic [N-1:0] e_rdy, e_dn;
      int w;
      w = winner(req_valid, m_last);
      e_rdy = (!job && w >= 0) ? (N'(1) << w) : '0;
      e_dn  = cur.dn ? (N'(1) << m_owner) : '0;
      got = {req_ready, done, done_timeout, busy, owner, tmr_chipselect, tmr_write_n,
             tmr_address, tmr_writedata};
      exp = {e_rdy, e_dn, cur.dn & cur.dto, job, PW'(m_owner), cur.cs, ~cur.cs,
             cur.addr, cur.data};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model cycle %0d: got %h required %h", cyc, got, exp);
      end
    end
  end

  // ---------------- timer responder ----------------
  int irq_cnt, irq_hold;
  always @(negedge clk) begin
    if (!reset_n) begin
      irq_auto = 0; irq_cnt = 0; irq_hold = 0;
    end else begin
      if (irq_hold > 0) begin
        irq_hold--;
        if (irq_hold == 0) irq_auto = 0;
      end
      if (irq_cnt > 0) begin
        irq_cnt--;
        if (irq_cnt == 0) begin irq_auto = 1; irq_hold = 2; end
      end
      if (auto_irq && tmr_chipselect && tmr_address == 3'd1 && tmr_writedata == 16'h0005)
        irq_cnt = 3;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [18:0] exp_q[$];
  logic [18:0] wr_log[$];
  int          gnt_log[$];
  int          done_cyc;
  bit          have_done, gap_chk;

  always @(negedge clk) begin
    if (reset_n) begin
      if (tmr_chipselect) wr_log.push_back({tmr_address, tmr_writedata});
      if (|(req_valid & req_ready)) begin
        for (int i = 0; i < N; i++)
          if (req_valid[i] & req_ready[i]) gnt_log.push_back(i);
        if (gap_chk && have_done) chk("idle_gap", 64'(cyc - done_cyc), 64'd1);
      end
      if (|done) begin done_cyc = cyc; have_done = 1; end
    end
  end

  task automatic ew(input logic [2:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic check_writes(input string nm);
    bit bad;
    int at;
    bad = (wr_log.size() != exp_q.size());
    at = -1;
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      if (at < 0 && wr_log[i] !== exp_q[i]) begin bad = 1; at = i; end
    checks++;
    if (bad) begin
      errors++;
      if (at >= 0)
        $display("FAIL %s: write %0d got %h required %h", nm, at, wr_log[at], exp_q[at]);
      else
        $display("FAIL %s: got %0d writes required %0d", nm, wr_log.size(), exp_q.size());
    end
    exp_q.delete();
    wr_log.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Leaves the caller at #1 into the cycle after the transfer.
  task automatic request(input int i, input logic [31:0] p);
    int n;
    bit ok;
    req_period[i*32 +: 32] = p;
    req_valid[i] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      ok = req_ready[i];
      n++;
    end while (!ok && n < 50);
    if (!ok) begin
      errors++; checks++;
      $display("FAIL accept_timeout: req %0d got no ready, required ready", i);
    end
    @(posedge clk);
    #1 req_valid[i] = 1'b0;
  endtask

  task automatic to_wait();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output logic [N-1:0] d, output logic dt);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done == '0 && n < 200);
    if (done == '0) begin
      errors++; checks++;
      $display("FAIL done_timeout_wait: got no done, required done");
    end
    d = done;
    dt = done_timeout;
  endtask

  // ---------------- directed tests ----------------
  logic [N-1:0] d;
  logic         dt;

  initial begin
    reset_n = 0; req_valid = '0; req_period = '0; req_cancel = '0;
    irq_man = 0; auto_irq = 0; gap_chk = 0; have_done = 0;
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done, done_timeout, owner},
        {1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, {N{1'b0}}, 1'b0, {PW{1'b0}}});
    @(posedge clk);
    #1 reset_n = 1;
    @(posedge clk);
    #1;

    // Single job, period 10, irq after a few WAIT cycles.
    wr_log.delete();
    request(0, 32'd10);
    to_wait();
    repeat (4) @(posedge clk);
    #1 irq_man = 1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 irq_man = 0;
    @(negedge clk);
    chk("single_done", {done, done_timeout}, {2'b01, 1'b1});
    @(posedge clk);
    #1;
    ew(1, 16'h0008); ew(2, 16'h000A); ew(3, 16'h0000); ew(0, 16'h0000); ew(1, 16'h0005);
    ew(0, 16'h0000);
    check_writes("single_writes");

    // Round-robin with both requesters held.
    do_reset();
    @(posedge clk);
    #1;
    gnt_log.delete(); wr_log.delete();
    auto_irq = 1; have_done = 0; gap_chk = 1;
    req_period = {32'd3, 32'd3};
    req_valid = 2'b11;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clk);
        #1;
        n++;
      end while (gnt_log.size() < 4 && n < 400);
    end
    @(posedge clk);
    #1 req_valid = '0;
    gap_chk = 0;
    wait_done(d, dt);
    chk("rr_last_done", {d, dt}, {2'b10, 1'b1});
    chk("rr_grants", {32'(gnt_log.size()), 8'(gnt_log[0]), 8'(gnt_log[1]), 8'(gnt_log[2]),
        8'(gnt_log[3])}, {32'd4, 8'd0, 8'd1, 8'd0, 8'd1});
    @(posedge clk);
    #1 auto_irq = 0;
    wr_log.delete();

    // Cancel from owner 1 after 20 WAIT cycles; cancel[0] meanwhile is ignored.
    request(1, 32'h0001_0000);
    to_wait();
    repeat (3) @(posedge clk);
    #1 req_cancel[0] = 1;
    repeat (2) @(posedge clk);
    #1 req_cancel[0] = 0;
    repeat (15) @(posedge clk);
    #1 req_cancel[1] = 1;
    @(posedge clk);
    #1 req_cancel[1] = 0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("cancel_done", {done, done_timeout}, {2'b10, 1'b0});
    @(posedge clk);
    #1;
    ew(1, 16'h0008); ew(2, 16'h0000); ew(3, 16'h0001); ew(0, 16'h0000); ew(1, 16'h0005);
    ew(1, 16'h0008); ew(0, 16'h0000);
    check_writes("cancel_writes");

    // irq and owner cancel in the same WAIT cycle: irq path wins.
    request(0, 32'd5);
    to_wait();
    repeat (2) @(posedge clk);
    #1 begin irq_man = 1; req_cancel[0] = 1; end
    @(posedge clk);
    #1 req_cancel[0] = 0;
    @(posedge clk);
    #1 irq_man = 0;
    @(negedge clk);
    chk("simul_done", {done, done_timeout}, {2'b01, 1'b1});
    @(posedge clk);
    #1;
    ew(1, 16'h0008); ew(2, 16'h0005); ew(3, 16'h0000); ew(0, 16'h0000); ew(1, 16'h0005);
    ew(0, 16'h0000);
    check_writes("simul_writes");

    // Period 0 is clamped to 1.
    auto_irq = 1;
    request(1, 32'd0);
    wait_done(d, dt);
    chk("period0_done", {d, dt}, {2'b10, 1'b1});
    @(posedge clk);
    #1 auto_irq = 0;
    ew(1, 16'h0008); ew(2, 16'h0001); ew(3, 16'h0000); ew(0, 16'h0000); ew(1, 16'h0005);
    ew(0, 16'h0000);
    check_writes("period0_writes");

    // Reset asserted mid-WAIT aborts at once; requester 0 wins afterwards.
    request(0, 32'd100);
    to_wait();
    repeat (3) @(posedge clk);
    #2 reset_n = 0;
    #1;
    chk("async_reset_outputs",
        {busy, tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata, done, owner},
        {1'b0, 1'b0, 1'b1, 3'd0, 16'h0000, {N{1'b0}}, {PW{1'b0}}});
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    gnt_log.delete();
    auto_irq = 1;
    req_period = {32'd2, 32'd2};
    req_valid = 2'b11;
    @(negedge clk);
    #1;
    chk("post_reset_grant", {32'(gnt_log.size()), 32'(gnt_log.size() > 0 ? gnt_log[0] : -1)},
        {32'd1, 32'd0});
    @(posedge clk);
    #1 req_valid = '0;
    wait_done(d, dt);
    chk("post_reset_done", {d, dt}, {2'b01, 1'b1});
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dircc_system_nios_single_timer_sequencer.md
# dircc_system_nios_single_timer_sequencer

Hardware sequencer that shares the single-shot interval timer (Avalon-MM slave, 16-bit registers: status @0, control @1, period_l @2, period_h @3) between NUM_REQ requesters. It arbitrates round-robin, programs the timer as an Avalon-MM master, and waits for the timer irq. It then clears the timeout and returns a per-requester done pulse, so the Nios core does not service timer interrupts for hardware timeouts.

## Interface
- NUM_REQ, 2, number of requesters (2..8).
- PTR_W, 3, width of grant index; must satisfy 2**PTR_W >= NUM_REQ.
- clk  in  1  single clock; everything synchronous to rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  request per requester; held until accepted.
- req_period  in  32*NUM_REQ  period for requester i in bits [32i+31:32i], in timer ticks.
- req_cancel  in  NUM_REQ  cancel; honoured only from the current owner, during WAIT.
- req_ready  out  NUM_REQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
- done  out  NUM_REQ  one-cycle pulse to the owner at job end.
- done_timeout  out  1  valid with done: 1 = timer expired, 0 = cancelled.
- busy  out  1  high in every state except IDLE.
- owner  out  PTR_W  index of current or last granted requester.
- tmr_address  out  3  timer register address.
- tmr_chipselect  out  1  timer select.
- tmr_write_n  out  1  active-low write.
- tmr_writedata  out  16  write data.
- tmr_irq  in  1  timer interrupt (level, registered at source).

## Operation
- States: IDLE, WR_STOP, WR_PL, WR_PH, WR_CLR, WR_START, WAIT, CSTOP, ACK, DONE.
- IDLE: the winner is the first requester with req_valid set, searching from last_grant+1 with wrap.
  - req_ready[winner] is asserted combinationally; all other bits are 0.
  - On transfer: latch period, set owner and last_grant, go to WR_STOP.
- Period 0 is clamped to 1. With period 0 the timer never produces a zero-crossing edge.
- Each WR_* state is one bus write (chipselect=1, write_n=0), one cycle, then advances in order:
  - WR_STOP: addr 1, data 0x0008 (stop, irq disabled).
  - WR_PL: addr 2, data period[15:0].
  - WR_PH: addr 3, data period[31:16].
  - WR_CLR: addr 0, data 0x0000 (clear stale timeout).
  - WR_START: addr 1, data 0x0005 (start, one-shot, irq enable).
- WAIT: bus idle. Exits on the first of:
  - tmr_irq=1: go to ACK, with timeout flag 1.
  - req_cancel[owner]=1: go to CSTOP, with timeout flag 0.
  - If both occur in the same cycle, the irq wins.
- CSTOP: addr 1, data 0x0008 (stop, irq disabled), then go to ACK.
- ACK: addr 0, data 0x0000 (clear status), then go to DONE.
- DONE: done[owner]=1 and done_timeout=flag for one cycle, then go to IDLE. New requests are accepted no earlier than the following IDLE cycle.
- req_cancel from a non-owner, or outside WAIT, is ignored. req_valid is not sampled outside IDLE.
- The bus is idle whenever no write is issued: chipselect=0, write_n=1, address=0, writedata=0.

## Timing
- Reset values: state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), owner=0, timeout flag 0. All outputs 0 except tmr_write_n=1.
- All tmr_* outputs, done, done_timeout and busy are decoded from the state register and latched data only. No input reaches them combinationally.
- Accept at cycle T. WR_STOP..WR_START occupy T+1..T+5. WAIT begins at T+6.
- Irq first seen high in WAIT at cycle K: ACK at K+1, DONE at K+2, IDLE at K+3.
- Cancel seen at cycle K: CSTOP at K+1, ACK at K+2, DONE at K+3.
- The timer has no waitrequest. Each write completes in its own cycle. tmr_irq falls one cycle after the ACK write and is ignored outside WAIT.
- Reset mid-job aborts immediately: no done pulse is produced, and the bus returns idle asynchronously.
- Back-to-back: with continuous requests, the idle gap between DONE and the next accept is exactly one IDLE cycle.

## Test plan
- Single job: req0 period 10. Expect ready at T; writes (1,0x0008), (2,0x000A), (3,0x0000), (0,0x0000), (1,0x0005) at T+1..T+5; done[0]=1 with done_timeout=1 two cycles after irq.
- Round-robin: req0 and req1 held continuously, period 3 each. Expect grants 0,1,0,1 and no starvation.
- Cancel: req1 period 0x0001_0000, cancel[1] 20 cycles into WAIT. Expect CSTOP write (1,0x0008), then ACK (0,0), then done[1]=1 with done_timeout=0. cancel[0] has no effect during that job.
- Simultaneous: irq and cancel[owner] in the same WAIT cycle. Expect the ACK path with done_timeout=1 and no CSTOP write.
- Period 0: expect period_l written as 0x0001, and done with done_timeout=1.
- Reset asserted in WAIT: outputs go to reset values at once; after release, requester 0 wins first.
